// File: rtl/color_pipe_if.sv
// rtl/color_pipe_if.sv - pixel, object, control and color signals of color_pipe
interface color_pipe_if #(
   parameter int N_PADDLES = 2
);
   logic [9:0]             DrawX;
   logic [9:0]             DrawY;
   logic                   blank;
   logic                   frame_start;
   logic [9:0]             BallX;
   logic [9:0]             BallY;
   logic [9:0]             Ball_size;
   logic [10*N_PADDLES-1:0] PaddleX;
   logic [10*N_PADDLES-1:0] PaddleY;
   logic [10*N_PADDLES-1:0] PaddleW;
   logic [10*N_PADDLES-1:0] PaddleL;
   logic                   goal;
   logic                   pause;
   logic [7:0]             Red;
   logic [7:0]             Green;
   logic [7:0]             Blue;
   logic                   pix_valid;

   modport master (
      output DrawX, DrawY, blank, frame_start,
      output BallX, BallY, Ball_size,
      output PaddleX, PaddleY, PaddleW, PaddleL,
      output goal, pause,
      input  Red, Green, Blue, pix_valid
   );

   modport slave (
      input  DrawX, DrawY, blank, frame_start,
      input  BallX, BallY, Ball_size,
      input  PaddleX, PaddleY, PaddleW, PaddleL,
      input  goal, pause,
      output Red, Green, Blue, pix_valid
   );
endinterface

// File: rtl/color_pipe.sv
// rtl/color_pipe.sv - two-stage Pong color mapper with goal flash and pause dim
module color_pipe #(
   parameter int N_PADDLES    = 2,
   parameter int FLASH_FRAMES = 30,
   parameter int FLASH_PERIOD = 4
) (
   input logic         Clk,
   input logic         Reset_n,
   color_pipe_if.slave bus
);

   localparam logic [7:0] FRAMES_LAST = 8'(FLASH_FRAMES);
   localparam logic [7:0] PERIOD_LAST = 8'(FLASH_PERIOD);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLASH = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  fcnt_q, fcnt_d;
   logic [7:0]  pcnt_q, pcnt_d;
   logic        phase_q, phase_d;

   logic        paddle_hit_q, paddle_hit_d;
   logic        ball_hit_q, ball_hit_d;
   logic [7:0]  bg_blue_q, bg_blue_d;
   logic        blank_q, blank_d;
   logic        phase_s1_q, phase_s1_d;
   logic        pause_q, pause_d;

   logic [23:0] rgb_q, rgb_d;
   logic        pix_valid_q, pix_valid_d;
   logic [23:0] rgb_mix;

   // Low bound clamps at 0 instead of wrapping; high bound has a spare bit so it never wraps.
   function automatic logic in_span(input logic [9:0] coord,
                                    input logic [9:0] center,
                                    input logic [9:0] half);
      logic [10:0] lo;
      logic [10:0] hi;
      lo = (center < half) ? 11'd0 : ({1'b0, center} - {1'b0, half});
      hi = {1'b0, center} + {1'b0, half};
      return ({1'b0, coord} >= lo) && ({1'b0, coord} <= hi);
   endfunction

   always_comb begin
      paddle_hit_d = 1'b0;
      for (int i = 0; i < N_PADDLES; i++) begin
         paddle_hit_d = paddle_hit_d
                      | (in_span(bus.DrawX, bus.PaddleX[10*i +: 10], bus.PaddleW[10*i +: 10])
                       & in_span(bus.DrawY, bus.PaddleY[10*i +: 10], bus.PaddleL[10*i +: 10]));
      end
      ball_hit_d = in_span(bus.DrawX, bus.BallX, bus.Ball_size)
                 & in_span(bus.DrawY, bus.BallY, bus.Ball_size);
      bg_blue_d  = 8'h7F - {1'b0, bus.DrawX[9:3]};
      blank_d    = bus.blank;
      phase_s1_d = phase_q;
      pause_d    = bus.pause;
   end

   // goal has priority over frame_start, so a coinciding frame is never counted.
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      pcnt_d  = pcnt_q;
      phase_d = phase_q;
      if (bus.goal) begin
         state_d = ST_FLASH;
         fcnt_d  = 8'd0;
         pcnt_d  = 8'd0;
         phase_d = 1'b1;
      end else if (state_q == ST_FLASH && bus.frame_start) begin
         if (fcnt_q + 8'd1 == FRAMES_LAST) begin
            state_d = ST_IDLE;
            fcnt_d  = 8'd0;
            pcnt_d  = 8'd0;
            phase_d = 1'b0;
         end else begin
            fcnt_d = fcnt_q + 8'd1;
            if (pcnt_q + 8'd1 == PERIOD_LAST) begin
               pcnt_d  = 8'd0;
               phase_d = ~phase_q;
            end else begin
               pcnt_d = pcnt_q + 8'd1;
            end
         end
      end
   end

   always_comb begin
      if (paddle_hit_q) begin
         rgb_mix = 24'hFFFFFF;
      end else if (ball_hit_q) begin
         rgb_mix = 24'hFF0000;
      end else if (phase_s1_q) begin
         rgb_mix = 24'hFFFF00;
      end else begin
         rgb_mix = {16'h0000, bg_blue_q};
      end
      if (pause_q) begin
         rgb_mix = {1'b0, rgb_mix[23:17], 1'b0, rgb_mix[15:9], 1'b0, rgb_mix[7:1]};
      end
      rgb_d       = blank_q ? 24'h000000 : rgb_mix;
      pix_valid_d = ~blank_q;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= ST_IDLE;
         fcnt_q       <= 8'd0;
         pcnt_q       <= 8'd0;
         phase_q      <= 1'b0;
         paddle_hit_q <= 1'b0;
         ball_hit_q   <= 1'b0;
         bg_blue_q    <= 8'd0;
         blank_q      <= 1'b0;
         phase_s1_q   <= 1'b0;
         pause_q      <= 1'b0;
         rgb_q        <= 24'h000000;
         pix_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         fcnt_q       <= fcnt_d;
         pcnt_q       <= pcnt_d;
         phase_q      <= phase_d;
         paddle_hit_q <= paddle_hit_d;
         ball_hit_q   <= ball_hit_d;
         bg_blue_q    <= bg_blue_d;
         blank_q      <= blank_d;
         phase_s1_q   <= phase_s1_d;
         pause_q      <= pause_d;
         rgb_q        <= rgb_d;
         pix_valid_q  <= pix_valid_d;
      end
   end

   assign bus.Red       = rgb_q[23:16];
   assign bus.Green     = rgb_q[15:8];
   assign bus.Blue      = rgb_q[7:0];
   assign bus.pix_valid = pix_valid_q;

endmodule

// File: tb/tb_color_pipe.sv
// tb/tb_color_pipe.sv - randomized and directed checks of color_pipe against a frame-level model
module tb_color_pipe;

   localparam int NP = 2;
   localparam int FF = 6;
   localparam int FP = 2;

   logic Clk;
   logic Reset_n;

   color_pipe_if #(.N_PADDLES(NP)) bus();

   color_pipe #(
      .N_PADDLES   (NP),
      .FLASH_FRAMES(FF),
      .FLASH_PERIOD(FP)
   ) dut (
      .Clk    (Clk),
      .Reset_n(Reset_n),
      .bus    (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int tests = 0;
   int fails = 0;
   string cur_tag = "init";

   int bx, by, bs;
   int px [NP];
   int py [NP];
   int pw [NP];
   int pl [NP];

   bit m_flash = 0;
   int m_k = 0;

   logic [31:0] expq [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit hit(int x, int y, int cx, int cy, int hx, int hy);
      int xlo, ylo;
      xlo = (cx - hx < 0) ? 0 : cx - hx;
      ylo = (cy - hy < 0) ? 0 : cy - hy;
      return (x >= xlo) && (x <= cx + hx) && (y >= ylo) && (y <= cy + hy);
   endfunction

   function automatic logic [31:0] expect_pix(int x, int y, bit bl, bit ps, bit ph);
      int r, g, b;
      bit pad;
      if (bl) return 32'h0;
      pad = 0;
      for (int i = 0; i < NP; i++)
         if (hit(x, y, px[i], py[i], pw[i], pl[i])) pad = 1;
      if (ph) begin r = 255; g = 255; b = 0; end
      else    begin r = 0;   g = 0;   b = 127 - x / 8; end
      if (hit(x, y, bx, by, bs, bs)) begin r = 255; g = 0; b = 0; end
      if (pad) begin r = 255; g = 255; b = 255; end
      if (ps) begin r = r / 2; g = g / 2; b = b / 2; end
      return {7'd0, 8'(r), 8'(g), 8'(b), 1'b1};
   endfunction

   task automatic drive(int x, int y, bit bl, bit fs, bit gl, bit ps);
      bit ph;
      @(posedge Clk);
      #1;
      if (expq.size() == 2)
         check(cur_tag, {7'd0, bus.Red, bus.Green, bus.Blue, bus.pix_valid}, expq.pop_front());
      bus.DrawX       = 10'(x);
      bus.DrawY       = 10'(y);
      bus.blank       = bl;
      bus.frame_start = fs;
      bus.goal        = gl;
      bus.pause       = ps;
      bus.BallX       = 10'(bx);
      bus.BallY       = 10'(by);
      bus.Ball_size   = 10'(bs);
      for (int i = 0; i < NP; i++) begin
         bus.PaddleX[10*i +: 10] = 10'(px[i]);
         bus.PaddleY[10*i +: 10] = 10'(py[i]);
         bus.PaddleW[10*i +: 10] = 10'(pw[i]);
         bus.PaddleL[10*i +: 10] = 10'(pl[i]);
      end
      ph = m_flash && (((m_k / FP) % 2) == 0);
      expq.push_back(expect_pix(x, y, bl, ps, ph));
      if (gl) begin
         m_flash = 1;
         m_k = 0;
      end else if (m_flash && fs) begin
         m_k++;
         if (m_k == FF) m_flash = 0;
      end
   endtask

   task automatic no_objects();
      bx = 1000; by = 1000; bs = 0;
      for (int i = 0; i < NP; i++) begin
         px[i] = 1000; py[i] = 1000; pw[i] = 0; pl[i] = 0;
      end
   endtask

   task automatic async_reset();
      #2;
      bus.goal        = 1'b0;
      bus.frame_start = 1'b0;
      Reset_n = 1'b0;
      #1;
      check("rst_rgb", {8'd0, bus.Red, bus.Green, bus.Blue}, 32'h0);
      check("rst_pv", {31'd0, bus.pix_valid}, 32'h0);
      repeat (2) @(posedge Clk);
      #3;
      Reset_n = 1'b1;
      expq.delete();
      m_flash = 0;
      m_k = 0;
   endtask

   initial begin
      Reset_n = 1'b0;
      no_objects();
      bus.DrawX = '0; bus.DrawY = '0; bus.blank = 1'b0; bus.frame_start = 1'b0;
      bus.goal = 1'b0; bus.pause = 1'b0;
      bus.BallX = '0; bus.BallY = '0; bus.Ball_size = '0;
      bus.PaddleX = '0; bus.PaddleY = '0; bus.PaddleW = '0; bus.PaddleL = '0;
      #2;
      check("reset_rgb", {8'd0, bus.Red, bus.Green, bus.Blue}, 32'h0);
      check("reset_pv", {31'd0, bus.pix_valid}, 32'h0);
      #20;
      Reset_n = 1'b1;

      cur_tag = "post_reset";
      drive(0, 10, 0, 0, 0, 0);
      drive(8, 10, 0, 0, 0, 0);

      cur_tag = "clamp";
      bx = 5; by = 100; bs = 8;
      drive(0, 100, 0, 0, 0, 0);
      drive(14, 100, 0, 0, 0, 0);
      drive(13, 100, 0, 0, 0, 0);
      drive(0, 108, 0, 0, 0, 0);
      drive(0, 109, 0, 0, 0, 0);

      cur_tag = "priority";
      px[0] = 20; py[0] = 240; pw[0] = 4; pl[0] = 24;
      bx = 22; by = 240; bs = 4;
      drive(22, 240, 0, 0, 0, 0);
      drive(26, 240, 0, 0, 0, 0);
      drive(27, 240, 0, 0, 0, 0);
      drive(20, 264, 0, 0, 0, 0);
      drive(20, 265, 0, 0, 0, 0);

      cur_tag = "gradient";
      no_objects();
      for (int x = 0; x < 640; x++)
         drive(x, 10, (x % 50) == 49, 0, 0, 0);

      cur_tag = "flash";
      drive(100, 20, 0, 0, 1, 0);
      for (int f = 0; f < 8; f++) begin
         for (int j = 0; j < 4; j++) drive($urandom_range(0, 639), 20, 0, 0, 0, 0);
         drive(200, 20, 0, 1, 0, 0);
      end

      cur_tag = "flash_restart";
      drive(100, 20, 0, 0, 1, 0);
      for (int f = 0; f < 10; f++) begin
         for (int j = 0; j < 3; j++) drive($urandom_range(0, 639), 20, 0, 0, 0, 0);
         drive(300, 20, 0, 1, f == 3, 0);
      end

      cur_tag = "pause";
      bx = 50; by = 50; bs = 5;
      drive(400, 400, 0, 0, 1, 0);
      drive(50, 50, 0, 0, 0, 1);
      drive(400, 400, 0, 0, 0, 1);
      drive(50, 50, 1, 0, 0, 1);
      drive(400, 400, 1, 0, 0, 1);
      drive(400, 400, 0, 0, 0, 0);

      cur_tag = "reset_mid_flash";
      drive(400, 400, 0, 0, 1, 0);
      drive(400, 400, 0, 1, 0, 0);
      async_reset();
      cur_tag = "after_reset";
      drive(0, 10, 0, 0, 0, 0);
      drive(400, 400, 0, 0, 0, 0);
      drive(400, 400, 0, 1, 0, 0);
      drive(80, 10, 0, 0, 0, 0);

      cur_tag = "random";
      for (int n = 0; n < 3000; n++) begin
         if (n % 64 == 0) begin
            bx = $urandom_range(0, 200); by = $urandom_range(0, 200); bs = $urandom_range(0, 40);
            for (int i = 0; i < NP; i++) begin
               px[i] = $urandom_range(0, 200); py[i] = $urandom_range(0, 200);
               pw[i] = $urandom_range(0, 30);  pl[i] = $urandom_range(0, 40);
            end
         end
         drive(($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 220),
               ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 220),
               $urandom_range(0, 7) == 0,
               $urandom_range(0, 9) == 0,
               $urandom_range(0, 79) == 0,
               $urandom_range(0, 3) == 0);
      end

      cur_tag = "flush";
      drive(0, 0, 1, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
